// File: rtl/bg_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous background ROM read port.
// Define BG_ROM_ARB_PIXEL_PRIORITY_EN to give requester 0 fixed top priority.
module bg_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 5,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
`ifdef BG_ROM_ARB_PIXEL_PRIORITY_EN
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [ADDR_W-1:0]  last_addr;
    logic [ADDR_W-1:0]  win_addr;
    logic               found;
    logic [NUM_REQ-1:0] pipe [ROM_LAT];

    always_comb begin : arb
        int idx;
        idx      = 0;
        gnt      = '0;
        found    = 1'b0;
        win_addr = last_addr;
        ptr_nxt  = ptr;
`ifdef BG_ROM_ARB_PIXEL_PRIORITY_EN
        if (reset_n && req[0]) begin
            gnt[0]   = 1'b1;
            found    = 1'b1;
            win_addr = addr[0 +: ADDR_W];
        end
        // Remaining requesters rotate over 1..NUM_REQ-1 only
        for (int o = 0; o < NUM_REQ - 1; o++) begin
            idx = 1 + ((int'(ptr) - 1 + o) % (NUM_REQ - 1));
            if (reset_n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                win_addr = addr[idx*ADDR_W +: ADDR_W];
                ptr_nxt  = (idx == NUM_REQ - 1) ? PTR_W'(1)
                                                : PTR_W'(idx + 1);
            end
        end
`else
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = (int'(ptr) + o) % NUM_REQ;
            if (reset_n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                win_addr = addr[idx*ADDR_W +: ADDR_W];
                ptr_nxt  = (idx == NUM_REQ - 1) ? '0
                                                : PTR_W'(idx + 1);
            end
        end
`endif
    end

    // Idle cycles replay the last address so the ROM input stays stable
    assign rom_address = win_addr;
    assign rd_valid    = pipe[ROM_LAT-1];
    assign rd_data     = rom_q;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) busy = busy | (|pipe[i]);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= PTR_RST;
            last_addr <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            ptr     <= ptr_nxt;
            pipe[0] <= gnt;
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
            if (found) last_addr <= win_addr;
        end
    end

endmodule
